// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game core.
package snake_pkg;

  // Movement direction; turning is modulo-4 arithmetic on this encoding.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  // Game state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // Pixel classes handed to the external colour mux.
  localparam logic [1:0] PIX_BG    = 2'd0;
  localparam logic [1:0] PIX_APPLE = 2'd1;
  localparam logic [1:0] PIX_BODY  = 2'd2;
  localparam logic [1:0] PIX_HEAD  = 2'd3;

  // Clockwise turn adds one, counter-clockwise subtracts one.
  function automatic dir_t turn_dir(input dir_t d, input logic cw);
    return cw ? dir_t'(d + 2'd1) : dir_t'(d - 2'd1);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell for a move in one direction, with wall or wrap handling.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = 30,
  parameter int GRID_H = 30,
  parameter int WRAP   = 0,
  parameter int XW     = $clog2(GRID_W),
  parameter int YW     = $clog2(GRID_H)
) (
  input  logic [XW-1:0] i_head_x,
  input  logic [YW-1:0] i_head_y,
  input  dir_t          i_dir,
  output logic [XW-1:0] o_nh_x,
  output logic [YW-1:0] o_nh_y,
  output logic          o_wall_hit
);

  // Move one cell; edges either wrap explicitly or flag a wall hit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_nh_x     = i_head_x;
    o_nh_y     = i_head_y;
    o_wall_hit = 1'b0;
    unique case (i_dir)
      UP: begin
        if (i_head_y == '0) begin
          if (WRAP != 0) o_nh_y = YW'(GRID_H - 1);
          else           o_wall_hit = 1'b1;
        end else begin
          o_nh_y = i_head_y - 1'b1;
        end
      end
      RIGHT: begin
        if (i_head_x == XW'(GRID_W - 1)) begin
          if (WRAP != 0) o_nh_x = '0;
          else           o_wall_hit = 1'b1;
        end else begin
          o_nh_x = i_head_x + 1'b1;
        end
      end
      DOWN: begin
        if (i_head_y == YW'(GRID_H - 1)) begin
          if (WRAP != 0) o_nh_y = '0;
          else           o_wall_hit = 1'b1;
        end else begin
          o_nh_y = i_head_y + 1'b1;
        end
      end
      LEFT: begin
        if (i_head_x == '0) begin
          if (WRAP != 0) o_nh_x = XW'(GRID_W - 1);
          else           o_wall_hit = 1'b1;
        end else begin
          o_nh_x = i_head_x - 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: body store, turn/step state machine and pixel classifier.
module snake_engine
  import snake_pkg::*;
#(
  parameter  int GRID_W    = 30,
  parameter  int GRID_H    = 30,
  parameter  int MAX_LEN   = 64,
  parameter  int INIT_LEN  = 3,
  parameter  int CELL_LOG2 = 1,
  parameter  int ORG_X     = 18,
  parameter  int ORG_Y     = 2,
  parameter  int WRAP      = 0,
  localparam int XW        = $clog2(GRID_W),
  localparam int YW        = $clog2(GRID_H),
  localparam int LW        = $clog2(MAX_LEN + 1)
) (
  input  logic          SLOW_CLOCK,
  input  logic          RESET_N,
  input  logic          tick,
  input  logic          start,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic [XW-1:0] apple_x,
  input  logic [YW-1:0] apple_y,
  input  logic          apple_valid,
  input  logic [6:0]    pixel_x,
  input  logic [5:0]    pixel_y,
  output logic [1:0]    pix_class,
  output logic          eat,
  output logic          dead,
  output logic [LW-1:0] length
);

  state_t        r_state, w_state_nxt;
  dir_t          r_dir, r_next_dir, w_eff_dir;
  logic          r_turn_pending;
  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];
  logic [LW-1:0] r_len, w_chk_len;
  logic          r_eat;

  logic [XW-1:0] w_nh_x;
  logic [YW-1:0] w_nh_y;
  logic          w_wall_hit, w_self_hit, w_collide, w_grow, w_step, w_turn_req, w_move;

  int            w_dx, w_dy;
  logic          w_in_grid, w_body_hit;
  logic [XW-1:0] w_cell_x;
  logic [YW-1:0] w_cell_y;

  assign w_eff_dir  = r_turn_pending ? r_next_dir : r_dir;
  assign w_step     = (r_state == RUN) && tick;
  assign w_turn_req = left_pulse ^ right_pulse;
  assign w_grow     = apple_valid && (w_nh_x == apple_x) && (w_nh_y == apple_y);
  assign w_collide  = w_wall_hit | w_self_hit;
  assign w_move     = w_step && !w_collide && !start;

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .WRAP   (WRAP),
    .XW     (XW),
    .YW     (YW)
  ) u_next_head (
    .i_head_x   (r_seg_x[0]),
    .i_head_y   (r_seg_y[0]),
    .i_dir      (w_eff_dir),
    .o_nh_x     (w_nh_x),
    .o_nh_y     (w_nh_y),
    .o_wall_hit (w_wall_hit)
  );

  // Self collision: the tail cell only counts when the snake is growing.
  always_comb begin
    w_chk_len  = w_grow ? r_len : r_len - 1'b1;
    w_self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < w_chk_len) && (r_seg_x[i] == w_nh_x) && (r_seg_y[i] == w_nh_y))
        w_self_hit = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge SLOW_CLOCK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: start always (re)enters RUN; a colliding step kills.
  always_comb begin
    w_state_nxt = r_state;
    if (start)                                      w_state_nxt = RUN;
    else if ((r_state == RUN) && w_step && w_collide) w_state_nxt = DEAD;
  end

  // State-derived outputs.
  always_comb begin
    dead = (r_state == DEAD);
  end

  assign eat    = r_eat;
  assign length = r_len;

  // Body store: reload the starting column on reset/start, shift on a move.
  always_ff @(posedge SLOW_CLOCK or negedge RESET_N) begin
    // NOTE: the segment array is reset because the classifier shows the start layout during reset.
    if (!RESET_N) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= XW'(GRID_W / 2);
        r_seg_y[i] <= YW'(GRID_H / 2 + i);
      end
    end else if (start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= XW'(GRID_W / 2);
        r_seg_y[i] <= YW'(GRID_H / 2 + i);
      end
    end else if (w_move) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= w_nh_x;
      r_seg_y[0] <= w_nh_y;
    end
  end

  // Direction, pending turn, length and eat pulse.
  always_ff @(posedge SLOW_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dir          <= UP;
      r_next_dir     <= UP;
      r_turn_pending <= 1'b0;
      r_len          <= LW'(INIT_LEN);
      r_eat          <= 1'b0;
    end else begin
      r_eat <= 1'b0;
      if (start) begin
        r_dir          <= UP;
        r_next_dir     <= UP;
        r_turn_pending <= 1'b0;
        r_len          <= LW'(INIT_LEN);
      end else if (w_move) begin
        r_dir <= w_eff_dir;
        // A pulse coinciding with the tick is queued against the new direction.
        r_turn_pending <= w_turn_req;
        r_next_dir     <= turn_dir(w_eff_dir, right_pulse);
        if (w_grow) begin
          r_eat <= 1'b1;
          if (r_len != LW'(MAX_LEN)) r_len <= r_len + 1'b1;
        end
      end else if ((r_state == RUN) && !r_turn_pending && w_turn_req) begin
        r_turn_pending <= 1'b1;
        r_next_dir     <= turn_dir(r_dir, right_pulse);
      end
    end
  end

  // Pixel to cell mapping; anything left/above the origin or past the grid is off-grid.
  always_comb begin
    w_dx      = int'(pixel_x) - ORG_X;
    w_dy      = int'(pixel_y) - ORG_Y;
    w_in_grid = (w_dx >= 0) && (w_dy >= 0) &&
                ((w_dx >>> CELL_LOG2) < GRID_W) && ((w_dy >>> CELL_LOG2) < GRID_H);
    w_cell_x  = XW'(w_dx >>> CELL_LOG2);
    w_cell_y  = YW'(w_dy >>> CELL_LOG2);
  end

  // Body membership over live segments 1..length-1.
  always_comb begin
    w_body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LW'(i) < r_len) && (r_seg_x[i] == w_cell_x) && (r_seg_y[i] == w_cell_y))
        w_body_hit = 1'b1;
    end
  end

  // Classify with priority head > body > apple > background.
  always_comb begin
    pix_class = PIX_BG;
    if (w_in_grid) begin
      if ((r_seg_x[0] == w_cell_x) && (r_seg_y[0] == w_cell_y))
        pix_class = PIX_HEAD;
      else if (w_body_hit)
        pix_class = PIX_BODY;
      else if (apple_valid && (apple_x == w_cell_x) && (apple_y == w_cell_y))
        pix_class = PIX_APPLE;
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: a wall-mode instance (MAX_LEN=5) and a
// wrap-mode instance share all inputs; expected values are hand-derived.
module tb_snake_engine;

  localparam int K_PIX  = 0;
  localparam int K_EAT  = 1;
  localparam int K_DEAD = 2;
  localparam int K_LEN  = 3;

  typedef struct {
    string name;
    int    kind;
    int    dut;
    int    px;
    int    py;
    int    val;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, left_pulse = 1'b0, right_pulse = 1'b0;
  logic [4:0] apple_x = '0, apple_y = '0;
  logic       apple_valid = 1'b0;
  logic [6:0] pixel_x = '0;
  logic [5:0] pixel_y = '0;

  logic [1:0] pc0, pc1;
  logic       eat0, eat1, dead0, dead1;
  logic [2:0] len0;
  logic [6:0] len1;

  item_t q[$];
  int    n_out    = 0;
  int    n_checks = 0;
  int    n_pass   = 0;

  always #5 clk = ~clk;

  snake_engine #(.MAX_LEN(5), .WRAP(0)) u_wall (
    .SLOW_CLOCK (clk), .RESET_N (rst_n), .tick (tick), .start (start),
    .left_pulse (left_pulse), .right_pulse (right_pulse),
    .apple_x (apple_x), .apple_y (apple_y), .apple_valid (apple_valid),
    .pixel_x (pixel_x), .pixel_y (pixel_y),
    .pix_class (pc0), .eat (eat0), .dead (dead0), .length (len0)
  );

  snake_engine #(.WRAP(1)) u_wrap (
    .SLOW_CLOCK (clk), .RESET_N (rst_n), .tick (tick), .start (start),
    .left_pulse (left_pulse), .right_pulse (right_pulse),
    .apple_x (apple_x), .apple_y (apple_y), .apple_valid (apple_valid),
    .pixel_x (pixel_x), .pixel_y (pixel_y),
    .pix_class (pc1), .eat (eat1), .dead (dead1), .length (len1)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- scoreboard push helpers ----------------
  task automatic exp_pix(input string nm, input int d, input int px, input int py, input int v);
    item_t it;
    it.name = nm; it.kind = K_PIX; it.dut = d; it.px = px; it.py = py; it.val = v;
    q.push_back(it);
    n_out++;
  endtask

  task automatic exp_cell(input string nm, input int d, input int cx, input int cy, input int v);
    exp_pix(nm, d, 18 + 2 * cx, 2 + 2 * cy, v);
  endtask

  task automatic exp_cell2(input string nm, input int cx, input int cy, input int v);
    exp_cell({nm, "_w0"}, 0, cx, cy, v);
    exp_cell({nm, "_w1"}, 1, cx, cy, v);
  endtask

  task automatic exp_sig(input string nm, input int d, input int k, input int v);
    item_t it;
    it.name = nm; it.kind = k; it.dut = d; it.px = 0; it.py = 0; it.val = v;
    q.push_back(it);
    n_out++;
  endtask

  task automatic exp_sig2(input string nm, input int k, input int v);
    exp_sig({nm, "_w0"}, 0, k, v);
    exp_sig({nm, "_w1"}, 1, k, v);
  endtask

  // Wait (bounded) until the monitor has compared everything queued.
  task automatic flush();
    int t = 0;
    while (n_out > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (n_out > 0) begin
      check("flush_timeout", n_out, 0);
      q.delete();
      n_out = 0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    item_t it;
    int    act;
    forever begin
      @(negedge clk);
      for (int n = 0; n < 4 && q.size() > 0; n++) begin
        it      = q.pop_front();
        pixel_x = 7'(it.px);
        pixel_y = 6'(it.py);
        #1;
        case (it.kind)
          K_PIX:   act = (it.dut == 0) ? int'(pc0)   : int'(pc1);
          K_EAT:   act = (it.dut == 0) ? int'(eat0)  : int'(eat1);
          K_DEAD:  act = (it.dut == 0) ? int'(dead0) : int'(dead1);
          default: act = (it.dut == 0) ? int'(len0)  : int'(len1);
        endcase
        check(it.name, act, it.val);
        n_out--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic pulse_right();
    right_pulse = 1'b1;
    cyc();
    right_pulse = 1'b0;
  endtask

  task automatic pulse_left();
    left_pulse = 1'b1;
    cyc();
    left_pulse = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset layout, visible while reset is held.
    repeat (2) cyc();
    exp_sig2("rst_dead", K_DEAD, 0);
    exp_sig2("rst_eat", K_EAT, 0);
    exp_sig2("rst_len", K_LEN, 3);
    exp_cell2("rst_head", 15, 15, 3);
    exp_cell2("rst_body1", 15, 16, 2);
    exp_cell2("rst_body2", 15, 17, 2);
    exp_cell2("rst_past_len", 15, 18, 0);
    exp_pix("rst_left_of_org", 0, 10, 32, 0);
    exp_pix("rst_past_grid", 0, 78, 32, 0);
    flush();
    rst_n = 1'b1;
    cyc();

    // Tick in IDLE does nothing.
    do_tick();
    exp_cell2("idle_head", 15, 15, 3);
    exp_cell2("idle_no_move", 15, 14, 0);
    flush();

    // Start and four plain ticks straight up.
    do_start();
    repeat (4) do_tick();
    exp_pix("run4_head_px", 0, 48, 24, 3);
    exp_pix("run4_head_px", 1, 48, 24, 3);
    exp_cell2("run4_body1", 15, 12, 2);
    exp_cell2("run4_body2", 15, 13, 2);
    exp_cell2("run4_vacated", 15, 14, 0);
    exp_sig2("run4_dead", K_DEAD, 0);
    exp_sig2("run4_len", K_LEN, 3);
    flush();

    // Right then left before the tick: only the right turn counts.
    pulse_right();
    pulse_left();
    do_tick();
    exp_cell2("turn_head", 16, 11, 3);
    exp_cell2("turn_not_up", 15, 10, 0);
    exp_cell2("turn_body", 15, 11, 2);
    flush();
    do_tick();
    exp_cell2("dir_right_head", 17, 11, 3);
    exp_cell2("dir_right_not_up", 17, 10, 0);
    flush();

    // Left and right together: no turn.
    left_pulse  = 1'b1;
    right_pulse = 1'b1;
    cyc();
    left_pulse  = 1'b0;
    right_pulse = 1'b0;
    do_tick();
    exp_cell2("both_head", 18, 11, 3);
    exp_cell2("both_not_down", 18, 12, 0);
    exp_cell2("both_not_up", 18, 10, 0);
    flush();

    // Apple display gated by apple_valid.
    apple_x = 5'd25; apple_y = 5'd5; apple_valid = 1'b1;
    exp_cell2("apple_shown", 25, 5, 1);
    flush();
    apple_valid = 1'b0;
    exp_cell2("apple_hidden", 25, 5, 0);
    flush();

    // Eat: apple on the next head cell.
    apple_x = 5'd19; apple_y = 5'd11; apple_valid = 1'b1;
    do_tick();
    exp_sig2("eat_pulse", K_EAT, 1);
    exp_sig2("eat_len", K_LEN, 4);
    exp_cell2("eat_head", 19, 11, 3);
    flush();
    cyc();
    exp_sig2("eat_one_cycle", K_EAT, 0);
    flush();
    apple_x = 5'd20; apple_y = 5'd11; apple_valid = 1'b0;
    do_tick();
    exp_sig2("noeat_invalid", K_EAT, 0);
    exp_sig2("noeat_len", K_LEN, 4);
    exp_cell2("noeat_head", 20, 11, 3);
    flush();

    // Tail chase around a 2x2 loop with length 4.
    repeat (4) begin
      pulse_right();
      do_tick();
    end
    exp_sig2("chase_dead", K_DEAD, 0);
    exp_sig2("chase_len", K_LEN, 4);
    exp_cell2("chase_head", 20, 11, 3);
    exp_cell2("chase_b1", 19, 11, 2);
    exp_cell2("chase_b2", 19, 12, 2);
    exp_cell2("chase_b3", 20, 12, 2);
    exp_cell2("chase_old", 18, 11, 0);
    flush();

    // Same move while growing bites the tail.
    pulse_right();
    apple_x = 5'd20; apple_y = 5'd12; apple_valid = 1'b1;
    do_tick();
    exp_sig2("grow_bite_eat", K_EAT, 0);
    exp_sig2("grow_bite_dead", K_DEAD, 1);
    exp_sig2("grow_bite_len", K_LEN, 4);
    exp_cell2("grow_bite_head", 20, 11, 3);
    exp_cell2("grow_bite_tail", 20, 12, 2);
    flush();
    apple_valid = 1'b0;
    pulse_left();
    do_tick();
    exp_cell2("dead_frozen_head", 20, 11, 3);
    exp_cell2("dead_frozen_tail", 20, 12, 2);
    exp_cell2("dead_no_move", 21, 11, 0);
    exp_sig2("dead_stays", K_DEAD, 1);
    flush();

    // Restart from DEAD.
    do_start();
    exp_sig2("restart_dead", K_DEAD, 0);
    exp_sig2("restart_len", K_LEN, 3);
    exp_cell2("restart_head", 15, 15, 3);
    exp_cell2("restart_body", 15, 16, 2);
    exp_cell2("restart_old", 20, 11, 0);
    flush();

    // Top wall: wall mode dies, wrap mode reappears at the bottom.
    repeat (15) do_tick();
    exp_cell2("top_row_head", 15, 0, 3);
    exp_sig2("top_row_alive", K_DEAD, 0);
    flush();
    do_tick();
    exp_sig("topwall_dead_w0", 0, K_DEAD, 1);
    exp_cell("topwall_head_w0", 0, 15, 0, 3);
    exp_cell("topwall_body_w0", 0, 15, 1, 2);
    exp_sig("topwrap_alive_w1", 1, K_DEAD, 0);
    exp_cell("topwrap_head_w1", 1, 15, 29, 3);
    exp_cell("topwrap_body_w1", 1, 15, 0, 2);
    flush();
    do_tick();
    exp_sig("topwall_still_dead_w0", 0, K_DEAD, 1);
    exp_cell("topwall_frozen_w0", 0, 15, 0, 3);
    exp_cell("topwrap_next_w1", 1, 15, 28, 3);
    flush();

    // Right wall / wrap across x. Wall instance restarts from DEAD, wrap from RUN.
    do_start();
    pulse_right();
    repeat (14) do_tick();
    exp_cell2("x29_head", 29, 15, 3);
    flush();
    do_tick();
    exp_sig("rwall_dead_w0", 0, K_DEAD, 1);
    exp_cell("rwall_head_w0", 0, 29, 15, 3);
    exp_sig("rwrap_alive_w1", 1, K_DEAD, 0);
    exp_cell("rwrap_head_w1", 1, 0, 15, 3);
    exp_cell("rwrap_body_w1", 1, 29, 15, 2);
    flush();
    pulse_right();
    do_tick();
    pulse_right();
    do_tick();
    exp_cell("lwrap_head_w1", 1, 29, 16, 3);
    exp_cell("lwrap_body_w1", 1, 0, 16, 2);
    exp_sig("lwrap_alive_w1", 1, K_DEAD, 0);
    exp_cell("rwall_frozen_w0", 0, 29, 15, 3);
    flush();

    // Length saturation (wall instance MAX_LEN=5).
    do_start();
    apple_x = 5'd15; apple_y = 5'd14; apple_valid = 1'b1;
    do_tick();
    exp_sig2("grow1_eat", K_EAT, 1);
    exp_sig2("grow1_len", K_LEN, 4);
    flush();
    apple_y = 5'd13;
    do_tick();
    exp_sig2("grow2_eat", K_EAT, 1);
    exp_sig2("grow2_len", K_LEN, 5);
    flush();
    apple_y = 5'd12;
    do_tick();
    exp_sig2("sat_eat", K_EAT, 1);
    exp_sig("sat_len_w0", 0, K_LEN, 5);
    exp_sig("grow3_len_w1", 1, K_LEN, 6);
    exp_cell2("sat_head", 15, 12, 3);
    exp_cell2("sat_body4", 15, 16, 2);
    exp_cell("sat_past_w0", 0, 15, 17, 0);
    exp_cell("grow3_body5_w1", 1, 15, 17, 2);
    flush();
    apple_valid = 1'b0;
    do_tick();
    exp_sig2("post_sat_eat", K_EAT, 0);
    exp_sig("post_sat_len_w0", 0, K_LEN, 5);
    exp_cell("post_sat_head_w0", 0, 15, 11, 3);
    exp_cell("post_sat_drop_w0", 0, 15, 16, 0);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
